y_alu_pipe: RTL and testbench
=============================

Y_ALU_PIPE -- requirements
Module: y_alu_pipe

Interface
REQ-001 Parameter W, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SW, default $clog2(W), shift-amount width; not overridden independently.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block accepts a new operation.
REQ-007 a, b  input  W  operands.
REQ-008 op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL, 100 SLL, 101 SRL.
REQ-009 out_valid  output  1  result registered and held.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 z  output  W  result.
REQ-012 zero  output  1  z equals 0.
REQ-013 ovf  output  1  signed overflow, ADD/SUB only.
REQ-014 err  output  1  op not supported in this build.

Function
REQ-015 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid & in_ready; a, b and op SHALL be captured on accept.
REQ-017 Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, SRL) SHALL go IDLE->DONE on accept, out_valid asserted the next cycle.
REQ-018 ADD/SUB: W-bit modulo result; SUB = a + ~b + 1; ovf = operand signs match (after b inversion for SUB) and result sign differs.
REQ-019 SLT: z = {W-1 zeros, (a<b signed)}, correct including overflow cases (sign-mismatch select).
REQ-020 SLL/SRL: shift a by b[SW-1:0], zero fill; b upper bits ignored.
REQ-021 MUL: IDLE->BUSY on accept, shift-add one bit of b per cycle for exactly W cycles, then DONE; z = low W bits of a*b (unsigned); out_valid W+1 cycles after accept.
REQ-022 ovf SHALL be 0 for all ops other than ADD/SUB; zero SHALL reflect z for every op.
REQ-023 DONE: z, zero, ovf, err held stable while out_ready=0; DONE->IDLE when out_ready=1.
REQ-024 in_valid during BUSY/DONE SHALL be ignored (not queued).
REQ-025 out_ready without out_valid SHALL have no effect.
REQ-026 Minimum throughput one op per 2 cycles (single-cycle ops, out_ready held 1).

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE, in_ready=1 the following cycle, out_valid=0, z=0, zero=1, ovf=0, err=0.
REQ-028 Reset during BUSY or DONE SHALL abandon the operation; no out_valid for it afterwards.

Configuration
REQ-029 Macro Y_ALU_MUL_EN defined: MUL implemented per REQ-021, err always 0.
REQ-030 Macro Y_ALU_MUL_EN undefined: no multiplier logic; op 011 completes as single-cycle op with z=0, zero=1, err=1; other ops unchanged.

Verification (W=32, Y_ALU_MUL_EN defined unless noted)
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> next cycle out_valid=1, z=0x80000000, ovf=1, zero=0.
REQ-032 SUB a=5 b=5 -> z=0, zero=1, ovf=0; SLT a=0x80000000 b=0x7FFFFFFF -> z=1; SLT a=1 b=0xFFFFFFFF -> z=0.
REQ-033 MUL a=7 b=6 -> in_ready=0 for 33 cycles, out_valid exactly 33 cycles after accept, z=42; MUL a=b=0x00010000 -> z=0, zero=1.
REQ-034 SLL a=1 b=0x00000025 -> z=0x00000020; hold out_ready=0 for 5 cycles -> z stable, in_ready=0, new in_valid ignored.
REQ-035 Start MUL, assert resetn=0 at cycle 10 -> next cycle IDLE, out_valid=0, zero=1; no stale result later.
REQ-036 Y_ALU_MUL_EN undefined: MUL a=3 b=4 -> next cycle out_valid=1, z=0, err=1; ADD 3+4 -> z=7, err=0.

Source files
------------

// File: rtl/y_alu_pipe_if.sv
// ---------------------------------------------------------------------------
// y_alu_pipe_if
// Handshake bundle between an operation producer and the y_alu_pipe ALU.
//
//   in_valid  : producer presents a, b, op
//   in_ready  : ALU can take a new operation (IDLE only)
//   a, b      : W-bit operands
//   op        : 3-bit operation code
//   out_valid : registered result is available and held
//   out_ready : consumer takes the result
//   z         : W-bit result
//   zero      : z == 0
//   ovf       : signed overflow (ADD/SUB only)
//   err       : operation not supported in this build
//
// Modports: master = producer/consumer side, slave = ALU side.
// ---------------------------------------------------------------------------
interface y_alu_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         zero;
    logic         ovf;
    logic         err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, zero, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, zero, ovf, err
    );
endinterface

// File: rtl/y_alu_pipe.sv
// ---------------------------------------------------------------------------
// y_alu_pipe
// Small handshaked ALU: AND, OR, ADD, SUB, SLT, SLL, SRL complete one cycle
// after acceptance; MUL (optional) is a W-step shift-add multiplier.
// One operation is in flight at a time (IDLE -> [BUSY ->] DONE -> IDLE).
//
// Ports:
//   clk     : clock, all state on the rising edge
//   resetn  : synchronous active-low reset
//   bus     : y_alu_pipe_if.slave (in_valid/in_ready/a/b/op in,
//             out_valid/out_ready/z/zero/ovf/err out)
//
// Build option:
//   Y_ALU_MUL_EN defined   : MUL implemented, err is always 0.
//   Y_ALU_MUL_EN undefined : no multiplier; op 011 completes in one cycle
//                            with z=0, zero=1, err=1.
// ---------------------------------------------------------------------------
module y_alu_pipe #(
    parameter int W  = 32,
    parameter int SW = $clog2(W)
) (
    input  logic        clk,
    input  logic        resetn,
    y_alu_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Overflow when both addends share a sign that the sum does not.
    function automatic logic add_ovf(input logic signed [W-1:0] x,
                                     input logic signed [W-1:0] y,
                                     input logic signed [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    // On a sign mismatch the difference may overflow, so the sign of x
    // alone decides; otherwise the sign of x - y is exact.
    function automatic logic slt_bit(input logic signed [W-1:0] x,
                                     input logic signed [W-1:0] y);
        logic signed [W-1:0] d;
        d = x - y;
        return (x[W-1] != y[W-1]) ? x[W-1] : d[W-1];
    endfunction

    state_t       state;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [W-1:0] z_r;
    logic         zero_r;
    logic         ovf_r;
    logic         err_r;

    logic         accept;
    logic         is_mul;
    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic [W-1:0] res;
    logic         res_ovf;
    logic         res_err;

    assign accept = bus.in_valid & in_ready_r;

    // Single-cycle result, computed from the operands at the accept edge.
    always_comb begin
        b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        sum     = bus.a + b_eff + {{(W-1){1'b0}}, (bus.op == OP_SUB)};
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (bus.op)
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_ADD, OP_SUB: begin
                res     = sum;
                res_ovf = add_ovf(bus.a, b_eff, sum);
            end
            OP_SLT: res = {{(W-1){1'b0}}, slt_bit(bus.a, bus.b)};
            OP_SLL: res = bus.a << bus.b[SW-1:0];
            OP_SRL: res = bus.a >> bus.b[SW-1:0];
            default: begin
`ifndef Y_ALU_MUL_EN
                res_err = 1'b1;
`endif
            end
        endcase
    end

`ifdef Y_ALU_MUL_EN
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [SW-1:0] cnt;

    assign is_mul   = (bus.op == OP_MUL);
    assign acc_next = acc + (mul_b[0] ? mul_a : '0);

    // Multiplier datapath: a shifts left, b shifts right, one bit per cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            mul_a <= bus.a;
            mul_b <= bus.b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            acc   <= acc_next;
            cnt   <= cnt + SW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            z_r         <= '0;
            zero_r      <= 1'b1;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready_r <= 1'b0;
                        if (is_mul) begin
                            state <= BUSY;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            z_r         <= res;
                            zero_r      <= (res == '0);
                            ovf_r       <= res_ovf;
                            err_r       <= res_err;
                        end
                    end
                end
`ifdef Y_ALU_MUL_EN
                BUSY: begin
                    // Last of the W steps lands directly in the result.
                    if (cnt == SW'(W-1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        z_r         <= acc_next;
                        zero_r      <= (acc_next == '0);
                        ovf_r       <= 1'b0;
                        err_r       <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.z         = z_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_y_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_y_alu_pipe
// Scoreboard bench for y_alu_pipe (W=32). Expected results come from a
// behavioural model using 64-bit signed arithmetic and are queued when an
// operation is driven, then popped when out_valid is observed.
// Works with Y_ALU_MUL_EN either defined or undefined.
// ---------------------------------------------------------------------------
module tb_y_alu_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] z;
        logic         zero;
        logic         ovf;
        logic         err;
    } res_t;

`ifdef Y_ALU_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    y_alu_pipe_if #(.W(W)) bus ();
    y_alu_pipe #(.W(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic res_t model(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        res_t   r;
        longint sa, sbv, s, lim;
        logic [63:0] p;
        r   = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lim = 64'sd2147483647;
        case (op)
            3'b000: r.z = a & b;
            3'b001: r.z = a | b;
            3'b010: begin
                s = sa + sbv;
                r.z = s[W-1:0];
                r.ovf = (s > lim) || (s < -lim - 1);
            end
            3'b110: begin
                s = sa - sbv;
                r.z = s[W-1:0];
                r.ovf = (s > lim) || (s < -lim - 1);
            end
            3'b111: r.z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100: r.z = a << b[4:0];
            3'b101: r.z = a >> b[4:0];
            default: begin
`ifdef Y_ALU_MUL_EN
                p = 64'(a) * 64'(b);
                r.z = p[W-1:0];
`else
                p = '0;
                r.z = p[W-1:0];
                r.err = 1'b1;
`endif
            end
        endcase
        r.zero = (r.z == '0);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.z = bus.z; r.zero = bus.zero; r.ovf = bus.ovf; r.err = bus.err;
        return r;
    endfunction

    // Present one operation while the DUT is idle; returns #1 after the accept edge.
    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; n counts edges from the accept edge (1 = next cycle).
    task automatic wait_out(input int limit, output bit ok, output int n, output bit rdy_seen);
        n = 1; ok = 1'b0; rdy_seen = 1'b0;
        while (n <= limit) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t exp, got;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp = '{z: '0, zero: 1'b1, ovf: 1'b0, err: 1'b0};
        got = observed();
        checks++;
        if (got !== exp || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got z=%h zero=%b ovf=%b err=%b out_valid=%b in_ready=%b, want z=0 zero=1 ovf=0 err=0 out_valid=0 in_ready=1",
                     got.z, got.zero, got.ovf, got.err, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_vectors();
        logic [2:0]   t_op [13] = '{3'b010, 3'b110, 3'b111, 3'b111, 3'b010, 3'b110, 3'b000,
                                    3'b001, 3'b100, 3'b101, 3'b010, 3'b111, 3'b110};
        logic [W-1:0] t_a  [13] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd1, 32'd3, 32'h80000000,
                                    32'h0000F0F0, 32'h0000F0F0, 32'd1, 32'h80000000, 32'hFFFFFFFF,
                                    32'h7FFFFFFF, 32'd0};
        logic [W-1:0] t_b  [13] = '{32'd1, 32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd1,
                                    32'h0000FF00, 32'h0000FF00, 32'h00000025, 32'h0000003F,
                                    32'd1, 32'h80000000, 32'd1};
        res_t exp, got;
        bit ok, rdy;
        int n;
        for (int i = 0; i < 13; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            wait_out(4, ok, n, rdy);
            exp = sb.pop_front();
            got = observed();
            checks++;
            if (!ok || n != 1 || got !== exp) begin
                errors++;
                $display("FAIL vec%0d op=%b a=%h b=%h: got valid=%b lat=%0d z=%h zero=%b ovf=%b err=%b, want lat=1 z=%h zero=%b ovf=%b err=%b",
                         i, t_op[i], t_a[i], t_b[i], ok, n, got.z, got.zero, got.ovf, got.err,
                         exp.z, exp.zero, exp.ovf, exp.err);
            end
            release_out();
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] m_a [4] = '{32'd7, 32'h00010000, 32'hFFFFFFFF, 32'd3};
        logic [W-1:0] m_b [4] = '{32'd6, 32'h00010000, 32'hFFFFFFFF, 32'd4};
        res_t exp, got;
        bit ok, rdy;
        int n;
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, m_a[i], m_b[i]);
            wait_out(MUL_LAT + 4, ok, n, rdy);
            exp = sb.pop_front();
            got = observed();
            checks++;
            if (!ok || n != MUL_LAT || rdy || got !== exp) begin
                errors++;
                $display("FAIL mul%0d a=%h b=%h: got valid=%b lat=%0d ready_seen=%b z=%h zero=%b err=%b, want lat=%0d ready_seen=0 z=%h zero=%b err=%b",
                         i, m_a[i], m_b[i], ok, n, rdy, got.z, got.zero, got.err,
                         MUL_LAT, exp.z, exp.zero, exp.err);
            end
            release_out();
        end
    endtask

    task automatic test_hold();
        res_t exp, got;
        bit ok, rdy;
        int n, seen;
        drive(3'b100, 32'd1, 32'h00000025);
        wait_out(4, ok, n, rdy);
        exp = sb.pop_front();
        got = observed();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL hold_first: got valid=%b z=%h, want z=%h", ok, got.z, exp.z);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.op = 3'b001; bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
            got = observed();
            checks++;
            if (got !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got z=%h out_valid=%b in_ready=%b, want z=%h out_valid=1 in_ready=0",
                         c, got.z, bus.out_valid, bus.in_ready, exp.z);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL hold_no_queue: got %0d out_valid cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};
        logic [2:0] op;
        logic [W-1:0] a, b;
        res_t exp, got;
        bus.out_ready = 1'b1;
        @(negedge clk);
        op = ops[$urandom_range(0, 6)]; a = $urandom; b = $urandom;
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = observed();
            checks++;
            if (bus.out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL b2b%0d: got out_valid=%b z=%h zero=%b ovf=%b, want out_valid=1 z=%h zero=%b ovf=%b",
                         i, bus.out_valid, got.z, got.zero, got.ovf, exp.z, exp.zero, exp.ovf);
            end
            if (i < 7) begin
                op = ops[$urandom_range(0, 6)]; a = $urandom; b = $urandom;
                bus.op = op; bus.a = a; bus.b = b;
                sb.push_back(model(op, a, b));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_idle%0d: got out_valid=%b in_ready=%b, want 0 1", i, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        res_t exp, got;
        bit ok, rdy;
        int n, seen;
        drive(3'b011, 32'd7, 32'd6);
        sb.delete();
        repeat (9) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        exp = '{z: '0, zero: 1'b1, ovf: 1'b0, err: 1'b0};
        got = observed();
        checks++;
        if (got !== exp || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got z=%h zero=%b out_valid=%b in_ready=%b, want z=0 zero=1 out_valid=0 in_ready=1",
                     got.z, got.zero, bus.out_valid, bus.in_ready);
        end
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_stale: got %0d out_valid cycles, want 0", seen);
        end
        drive(3'b010, 32'd3, 32'd4);
        wait_out(4, ok, n, rdy);
        exp = sb.pop_front();
        got = observed();
        checks++;
        if (!ok || n != 1 || got !== exp) begin
            errors++;
            $display("FAIL mid_reset_recover: got valid=%b lat=%0d z=%h err=%b, want lat=1 z=%h err=%b",
                     ok, n, got.z, got.err, exp.z, exp.err);
        end
        release_out();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_vectors();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
